// File: rtl/mc_maindec.sv
// Main control FSM for the multicycle tinymips datapath.
// Moore decode of the state register; write strobes are qualified by run-enable and reset.
module mc_maindec (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic [5:0] op,
   output logic [3:0] state,
   output logic       iord,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] aluop,
   output logic [1:0] pcsrc,
   output logic       regdst,
   output logic       memtoreg,
   output logic       irwrite,
   output logic       pcwrite,
   output logic       branch,
   output logic       regwrite,
   output logic       memwrite
);

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      EXECUTE = 4'd6,
      ALUWB   = 4'd7,
      BRANCH  = 4'd8,
      ADDIEX  = 4'd9,
      ADDIWB  = 4'd10,
      JUMP    = 4'd11
   } state_e;

   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   logic [3:0] state_q, state_d;
   logic [3:0] dec_state;
   logic       strobe_en;
   logic       irwrite_raw, pcwrite_raw, branch_raw, regwrite_raw, memwrite_raw;

   always_comb begin
      state_d = FETCH;
      case (state_q)
         FETCH:   state_d = DECODE;
         DECODE: begin
            case (op)
               OP_LW, OP_SW: state_d = MEMADR;
               OP_RTYPE:     state_d = EXECUTE;
               OP_BEQ:       state_d = BRANCH;
               OP_ADDI:      state_d = ADDIEX;
               OP_J:         state_d = JUMP;
               default:      state_d = FETCH;
            endcase
         end
         MEMADR:  state_d = (op == OP_LW) ? MEMRD : MEMWR;
         MEMRD:   state_d = MEMWB;
         EXECUTE: state_d = ALUWB;
         ADDIEX:  state_d = ADDIWB;
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset)
         state_q <= FETCH;
      else if (en)
         state_q <= state_d;
   end

   // During reset the selects already present FETCH so the first fetch sees stable muxes.
   assign dec_state = reset ? 4'(FETCH) : state_q;
   assign strobe_en = en & ~reset;

   always_comb begin
      iord         = 1'b0;
      alusrca      = 1'b0;
      alusrcb      = 2'b00;
      aluop        = 2'b00;
      pcsrc        = 2'b00;
      regdst       = 1'b0;
      memtoreg     = 1'b0;
      irwrite_raw  = 1'b0;
      pcwrite_raw  = 1'b0;
      branch_raw   = 1'b0;
      regwrite_raw = 1'b0;
      memwrite_raw = 1'b0;
      case (dec_state)
         FETCH:   begin alusrcb = 2'b01; irwrite_raw = 1'b1; pcwrite_raw = 1'b1; end
         DECODE:  alusrcb = 2'b11;
         MEMADR:  begin alusrca = 1'b1; alusrcb = 2'b10; end
         MEMRD:   iord = 1'b1;
         MEMWB:   begin memtoreg = 1'b1; regwrite_raw = 1'b1; end
         MEMWR:   begin iord = 1'b1; memwrite_raw = 1'b1; end
         EXECUTE: begin alusrca = 1'b1; aluop = 2'b10; end
         ALUWB:   begin regdst = 1'b1; regwrite_raw = 1'b1; end
         BRANCH:  begin alusrca = 1'b1; aluop = 2'b01; pcsrc = 2'b01; branch_raw = 1'b1; end
         ADDIEX:  begin alusrca = 1'b1; alusrcb = 2'b10; end
         ADDIWB:  regwrite_raw = 1'b1;
         JUMP:    begin pcsrc = 2'b10; pcwrite_raw = 1'b1; end
         default: ;
      endcase
   end

   assign state    = state_q;
   assign irwrite  = irwrite_raw  & strobe_en;
   assign pcwrite  = pcwrite_raw  & strobe_en;
   assign branch   = branch_raw   & strobe_en;
   assign regwrite = regwrite_raw & strobe_en;
   assign memwrite = memwrite_raw & strobe_en;

endmodule

// File: tb/tb_mc_maindec.sv
// Directed bench for mc_maindec: walks every instruction class, enable holds,
// mid-instruction reset and recovery from an illegal state code.
module tb_mc_maindec;

   logic       clk, reset, en;
   logic [5:0] op;
   logic [3:0] state;
   logic       iord, alusrca, regdst, memtoreg;
   logic [1:0] alusrcb, aluop, pcsrc;
   logic       irwrite, pcwrite, branch, regwrite, memwrite;

   int n_cmp = 0;
   int n_err = 0;

   mc_maindec dut (
      .clk(clk), .reset(reset), .en(en), .op(op), .state(state),
      .iord(iord), .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop),
      .pcsrc(pcsrc), .regdst(regdst), .memtoreg(memtoreg),
      .irwrite(irwrite), .pcwrite(pcwrite), .branch(branch),
      .regwrite(regwrite), .memwrite(memwrite)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {iord, alusrca, alusrcb, aluop, pcsrc, regdst, memtoreg, irwrite, pcwrite, branch, regwrite, memwrite}
   function automatic logic [14:0] expo(input logic [3:0] st, input logic e, input logic r);
      logic [14:0] v;
      logic [3:0]  s;
      s = r ? 4'd0 : st;
      case (s)
         4'd0:    v = 15'b0_0_01_00_00_0_0_1_1_0_0_0;
         4'd1:    v = 15'b0_0_11_00_00_0_0_0_0_0_0_0;
         4'd2:    v = 15'b0_1_10_00_00_0_0_0_0_0_0_0;
         4'd3:    v = 15'b1_0_00_00_00_0_0_0_0_0_0_0;
         4'd4:    v = 15'b0_0_00_00_00_0_1_0_0_0_1_0;
         4'd5:    v = 15'b1_0_00_00_00_0_0_0_0_0_0_1;
         4'd6:    v = 15'b0_1_00_10_00_0_0_0_0_0_0_0;
         4'd7:    v = 15'b0_0_00_00_00_1_0_0_0_0_1_0;
         4'd8:    v = 15'b0_1_00_01_01_0_0_0_0_1_0_0;
         4'd9:    v = 15'b0_1_10_00_00_0_0_0_0_0_0_0;
         4'd10:   v = 15'b0_0_00_00_00_0_0_0_0_0_1_0;
         4'd11:   v = 15'b0_0_00_00_10_0_0_0_1_0_0_0;
         default: v = 15'b0;
      endcase
      if (!(e && !r)) v[4:0] = 5'b0;
      return v;
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Check the current cycle (state + all outputs) then advance one clock.
   task automatic cyc(input string tag, input logic [3:0] es);
      logic [14:0] outs;
      #1;
      outs = {iord, alusrca, alusrcb, aluop, pcsrc, regdst, memtoreg,
              irwrite, pcwrite, branch, regwrite, memwrite};
      chk({tag, "_state"}, {12'b0, state}, {12'b0, es});
      chk({tag, "_outs"}, {1'b0, outs}, {1'b0, expo(es, en, reset)});
      @(negedge clk);
   endtask

   // seq holds the expected state codes, first state in the low nibble.
   task automatic run(input string name, input logic [5:0] o, input int n, input logic [23:0] seq);
      logic [23:0] s;
      s = seq;
      op = o;
      en = 1'b1;
      for (int i = 0; i < n; i++) cyc(name, s[4*i +: 4]);
      $display("instr %-6s op=%b cycles=%0d compared=%0d", name, o, n, n_cmp);
   endtask

   initial begin
      reset = 1'b1; en = 1'b0; op = 6'b0;
      @(negedge clk);
      cyc("rst_en0", 4'd0);
      en = 1'b1;
      cyc("rst_en1", 4'd0);
      reset = 1'b0;

      run("LW",    6'b100011, 5, 24'h043210);
      run("SW",    6'b101011, 4, 24'h005210);
      run("RTYPE", 6'b000000, 4, 24'h007610);
      run("ADDI",  6'b001000, 4, 24'h00A910);
      run("BEQ",   6'b000100, 3, 24'h000810);
      run("J",     6'b000010, 3, 24'h000B10);
      run("UNK",   6'b111111, 2, 24'h000010);

      // Freeze in MEMWR for three cycles, then let the store complete.
      op = 6'b101011; en = 1'b1;
      cyc("hold_a", 4'd0);
      cyc("hold_b", 4'd1);
      cyc("hold_c", 4'd2);
      en = 1'b0;
      for (int i = 0; i < 3; i++) cyc("hold_frz", 4'd5);
      en = 1'b1;
      cyc("hold_rel", 4'd5);
      cyc("hold_end", 4'd0);
      $display("instr HOLD   op=%b cycles=7 compared=%0d", op, n_cmp);

      // Reset arriving in ALUWB must suppress regwrite and restart at FETCH.
      op = 6'b000000;
      cyc("mrst_a", 4'd1);
      cyc("mrst_b", 4'd6);
      reset = 1'b1;
      cyc("mrst_wb", 4'd7);
      reset = 1'b0;
      cyc("mrst_fetch", 4'd0);
      $display("instr MRST   op=%b compared=%0d", op, n_cmp);

      // Illegal code 13 decodes to nothing and returns to FETCH.
      force dut.state_q = 4'd13;
      #1;
      release dut.state_q;
      en = 1'b1;
      cyc("illegal", 4'd13);
      cyc("ill_fetch", 4'd0);
      $display("instr ILL    state=13 compared=%0d", n_cmp);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
